// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA command arbiter: command/response field
// layout, reserved-bit handling and FSM state encoding.
package esfa_pkg;

    localparam int CMD_W           = 48;
    localparam int RSP_W           = 48;
    localparam int FIELD_W         = 8;

    localparam int CMD_WILLWRITE_BIT = 0;
    localparam int CMD_INDEX_LSB     = 8;
    localparam int CMD_VALUE_LSB     = 16;
    localparam int CMD_META_LSB      = 24;
    localparam int CMD_ISMETA_BIT    = 32;
    localparam int CMD_SEL_LSB       = 40;

    // Bits [7:1] and [39:33] are reserved and never reach the datapath.
    localparam logic [CMD_W-1:0] CMD_RSVD_MASK = 48'h00FE_0000_00FE;
    localparam logic [CMD_W-1:0] CMD_KEEP_MASK = ~CMD_RSVD_MASK;

    localparam int RSP_BOOL_LSB  = 0;
    localparam int RSP_VALUE_LSB = 8;
    localparam int RSP_CAPT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } esfa_state_e;

    function automatic logic [CMD_W-1:0] esfa_clear_rsvd(input logic [CMD_W-1:0] cmd);
        return cmd & CMD_KEEP_MASK;
    endfunction

endpackage

// File: rtl/esfa_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module esfa_rr_arb2
    import esfa_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Grant selection from current valids and the previous winner.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = 1'b0;
        if (valid0_i && valid1_i) begin
            gnt_valid_o = 1'b1;
            gnt_id_o    = ~last_grant_i;
        end else if (valid1_i) begin
            gnt_valid_o = 1'b1;
            gnt_id_o    = 1'b1;
        end else if (valid0_i) begin
            gnt_valid_o = 1'b1;
            gnt_id_o    = 1'b0;
        end else begin
            gnt_valid_o = 1'b0;
            gnt_id_o    = 1'b0;
        end
    end

endmodule

// File: rtl/esfa_cmd_arbiter.sv
// Arbitrates two 48-bit command requesters onto one ESFA datapath, one
// transaction in flight, and returns the captured 16-bit result to the owner.
module esfa_cmd_arbiter
    import esfa_pkg::*;
#(
    parameter int unsigned RESP_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CMD_W-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CMD_W-1:0] req1_data,
    output logic [CMD_W-1:0] esfa_cmd,
    input  logic [RSP_W-1:0] esfa_rsp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [RSP_CAPT_W-1:0] rsp_data,
    output logic             busy
);

    esfa_state_e         state_q, state_d;
    logic [CMD_W-1:0]    esfa_cmd_q, esfa_cmd_d;
    logic                id_q, id_d;
    logic                last_q, last_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [RSP_CAPT_W-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_id_q, rsp_id_d;
    logic                ready0_s, ready1_s;
    logic                gnt_valid_s, gnt_id_s;
    logic [CMD_W-1:0]    gnt_data_s;
    logic                unused_rsp_s;

    assign unused_rsp_s = ^esfa_rsp[RSP_W-1:RSP_CAPT_W];

    esfa_rr_arb2 u_arb (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_q),
        .gnt_valid_o  (gnt_valid_s),
        .gnt_id_o     (gnt_id_s)
    );

    assign gnt_data_s = gnt_id_s ? req1_data : req0_data;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            esfa_cmd_q <= 48'h0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            rsp_data_q <= 16'h0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            esfa_cmd_q <= esfa_cmd_d;
            id_q       <= id_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    // Next-state logic; esfa_cmd_d defaults to zero so the command is only
    // presented during the single ISSUE cycle.
    always_comb begin
        state_d    = state_q;
        esfa_cmd_d = 48'h0;
        id_d       = id_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        ready0_s   = 1'b0;
        ready1_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    ready0_s   = ~gnt_id_s;
                    ready1_s   = gnt_id_s;
                    esfa_cmd_d = esfa_clear_rsvd(gnt_data_s);
                    id_d       = gnt_id_s;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 4'(RESP_LATENCY);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    rsp_data_d = esfa_rsp[RSP_VALUE_LSB+FIELD_W-1:RSP_BOOL_LSB];
                    rsp_id_d   = id_q;
                    cnt_d      = 4'd0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is combinational from valid, so reset must gate it directly.
    assign req0_ready = ready0_s & ~rst;
    assign req1_ready = ready1_s & ~rst;
    assign esfa_cmd   = esfa_cmd_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_esfa_cmd_arbiter.sv
// Directed self-checking bench for esfa_cmd_arbiter with RESP_LATENCY=2.
module tb_esfa_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [47:0] req0_data, req1_data, esfa_cmd, esfa_rsp;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_data;
    int          pass_cnt;
    int          chk_cnt;

    esfa_cmd_arbiter #(.RESP_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .esfa_cmd(esfa_cmd), .esfa_rsp(esfa_rsp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_data = 48'h0; req1_data = 48'h0; esfa_rsp = 48'h0;
        tick(); tick();
        chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b want 0", req0_ready); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (esfa_cmd !== 48'h0) $display("FAIL rst_cmd: got %h want 0", esfa_cmd); else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rel_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (esfa_cmd !== 48'h0) $display("FAIL rel_cmd: got %h want 0", esfa_cmd); else pass_cnt++;
        chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL rel_ready0: got %b want 1", req0_ready); else pass_cnt++;
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_cmd();
        req0_data = 48'h0000002A0501; req0_valid = 1'b1; esfa_rsp = 48'h0000_0000_AAAA;
        #1;
        chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", req0_ready); else pass_cnt++;
        tick();
        req0_valid = 1'b0;
        #1;
        chk_cnt++; if (esfa_cmd !== 48'h0000002A0501) $display("FAIL single_cmd: got %h want 0000002a0501", esfa_cmd); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
        chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL single_ready_issue: got %b want 0", req0_ready); else pass_cnt++;
        tick();
        esfa_rsp = 48'h0000_0000_BBBB;
        chk_cnt++; if (esfa_cmd !== 48'h0) $display("FAIL single_cmd_1cyc: got %h want 0", esfa_cmd); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_early1: got %b want 0", rsp_valid); else pass_cnt++;
        tick();
        esfa_rsp = 48'h0000_0000_01FF;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_early2: got %b want 0", rsp_valid); else pass_cnt++;
        tick();
        esfa_rsp = 48'h0000_0000_CCCC; rsp_ready = 1'b1;
        chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_id !== 1'b0) $display("FAIL single_rsp_id: got %b want 0", rsp_id); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 16'h01FF) $display("FAIL single_rsp_data: got %h want 01ff", rsp_data); else pass_cnt++;
        tick();
        rsp_ready = 1'b0;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_done_valid: got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_done_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int  acc_cyc[$];
        bit  acc_id[$];
        int  both_err;
        both_err = 0;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_data = 48'h0000_0000_1100; req1_data = 48'h0000_0000_2200;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (req0_ready && req1_ready) both_err++;
            if (req0_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b0); end
            else if (req1_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b1); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rsp_ready = 1'b0;
        chk_cnt++; if (both_err !== 0) $display("FAIL rr_one_ready: got %0d overlaps want 0", both_err); else pass_cnt++;
        chk_cnt++;
        if (acc_id.size() < 4) $display("FAIL rr_count: got %0d accepts want >=4", acc_id.size());
        else begin
            pass_cnt++;
            for (int k = 0; k < 4; k++) begin
                chk_cnt++; if (acc_id[k] !== k[0]) $display("FAIL rr_grant%0d: got %0d want %0d", k, acc_id[k], k[0]); else pass_cnt++;
            end
            for (int k = 1; k < 4; k++) begin
                chk_cnt++; if (acc_cyc[k] - acc_cyc[k-1] !== 5) $display("FAIL rr_spacing%0d: got %0d want 5", k, acc_cyc[k] - acc_cyc[k-1]); else pass_cnt++;
            end
        end
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rr_drain_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        req0_data = 48'h0000_0000_1301; req0_valid = 1'b1; esfa_rsp = 48'h0000_0000_5A5A;
        #1;
        chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL bp_ready: got %b want 1", req0_ready); else pass_cnt++;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            esfa_rsp = {32'h0, 16'h1111 * 16'(i + 1)};
            #1;
            chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, rsp_valid); else pass_cnt++;
            chk_cnt++; if (rsp_data !== 16'h5A5A) $display("FAIL bp_data%0d: got %h want 5a5a", i, rsp_data); else pass_cnt++;
            chk_cnt++; if (rsp_id !== 1'b0) $display("FAIL bp_id%0d: got %b want 0", i, rsp_id); else pass_cnt++;
            chk_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_ready%0d: got %b want 00", i, {req0_ready, req1_ready}); else pass_cnt++;
            chk_cnt++; if (esfa_cmd !== 48'h0) $display("FAIL bp_cmd%0d: got %h want 0", i, esfa_cmd); else pass_cnt++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req1_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_done_valid: got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL bp_done_busy: got %b want 0", busy); else pass_cnt++;
        tick();
    endtask

    task automatic test_reserved_mask();
        bit ok;
        req1_data = 48'hFFFFFFFFFFFF; req1_valid = 1'b1; esfa_rsp = 48'h0000_0000_0077;
        #1;
        chk_cnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL mask_ready: got %b want 01", {req0_ready, req1_ready}); else pass_cnt++;
        tick();
        req1_valid = 1'b0; rsp_ready = 1'b1;
        chk_cnt++; if (esfa_cmd !== 48'hFF01FFFFFF01) $display("FAIL mask_cmd: got %h want ff01ffffff01", esfa_cmd); else pass_cnt++;
        wait_rsp(ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL mask_rsp_timeout: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (rsp_id !== 1'b1) $display("FAIL mask_rsp_id: got %b want 1", rsp_id); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 16'h0077) $display("FAIL mask_rsp_data: got %h want 0077", rsp_data); else pass_cnt++;
        tick();
        rsp_ready = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mask_done_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int seen;
        seen = 0;
        req0_data = 48'h0000_0000_0101; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1; req0_valid = 1'b1;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (esfa_cmd !== 48'h0) $display("FAIL mid_cmd: got %h want 0", esfa_cmd); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 16'h0) $display("FAIL mid_rsp_data: got %h want 0", rsp_data); else pass_cnt++;
        chk_cnt++; if (rsp_id !== 1'b0) $display("FAIL mid_rsp_id: got %b want 0", rsp_id); else pass_cnt++;
        chk_cnt++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) $display("FAIL mid_flags: got %b want 000", {req0_ready, req1_ready, rsp_valid}); else pass_cnt++;
        tick(); tick();
        rst = 1'b0; req0_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        chk_cnt++; if (seen !== 0) $display("FAIL mid_no_rsp: got %0d cycles want 0", seen); else pass_cnt++;
        req0_data = 48'h0000_0000_4400; req1_data = 48'h0000_0000_5500;
        req0_valid = 1'b1; req1_valid = 1'b1; esfa_rsp = 48'h0000_0000_3C3C;
        #1;
        chk_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_regrant: got %b want 10", {req0_ready, req1_ready}); else pass_cnt++;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk_cnt++; if (esfa_cmd !== 48'h0000_0000_4400) $display("FAIL mid_next_cmd: got %h want 000000004400", esfa_cmd); else pass_cnt++;
        wait_rsp(ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL mid_next_timeout: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (rsp_id !== 1'b0) $display("FAIL mid_next_id: got %b want 0", rsp_id); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 16'h3C3C) $display("FAIL mid_next_data: got %h want 3c3c", rsp_data); else pass_cnt++;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        test_reset();
        test_single_cmd();
        test_round_robin();
        test_backpressure();
        test_reserved_mask();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
